mac_rtc: RTL and testbench

MAC_RTC -- requirements
Module: mac_rtc

---
 rtl/mac_rtc_if.sv | 25 ++
 rtl/mac_rtc.sv | 176 +++++++++++++++++
 tb/tb_mac_rtc.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rtc_if.sv
// Serial RTC bus between the VIA port B pins and the clock chip.
// The master side is the VIA; the slave side is mac_rtc.
interface mac_rtc_if;
    logic rtc_ce_n;
    logic rtc_clk;
    logic rtc_data_i;
    logic rtc_data_o;
    logic rtc_data_t;

    modport master (
        output rtc_ce_n,
        output rtc_clk,
        output rtc_data_i,
        input  rtc_data_o,
        input  rtc_data_t
    );

    modport slave (
        input  rtc_ce_n,
        input  rtc_clk,
        input  rtc_data_i,
        output rtc_data_o,
        output rtc_data_t
    );
endinterface

// File: rtl/mac_rtc.sv
// Macintosh-style real-time clock: 32-bit seconds counter, 20 bytes of PRAM, serial access.
// Define MAC_RTC_PRAM_INIT_EN to have reset load the PRAM defaults.
module mac_rtc (
    input  logic        clock,
    input  logic        reset,
    input  logic        sec_tick,
    input  logic        time_set,
    input  logic [31:0] time_in,
    mac_rtc_if.slave    rtc
);

    typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StHold} state_e;

    state_e      state_q;
    logic        clk_q, clk_prev_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [4:0]  addr_q;
    logic        commit_q;
    logic        wp_q;
    logic [31:0] seconds_q;
    logic        data_o_q, data_t_q;

`ifdef MAC_RTC_PRAM_INIT_EN
    logic [7:0]  pram_q [20];
`else
    logic [7:0]  pram_q [20] = '{default: 8'h00};
`endif

    logic       rise, fall, last_edge;
    logic [7:0] in_byte;
    logic [4:0] rd_addr;
    logic [7:0] rd_byte;
    logic       pram_we;

    // PRAM slots 0..15 hold bytes 0x00-0x0F, slots 16..19 hold bytes 0x10-0x13.
    function automatic logic [4:0] pram_index(input logic [4:0] a);
        return a[4] ? {1'b0, a[3:0]} : {3'b100, a[1:0]};
    endfunction

    function automatic logic is_pram(input logic [4:0] a);
        return a[4] || (a[4:2] == 3'b010);
    endfunction

    function automatic logic addr_valid(input logic [4:0] a);
        return is_pram(a) || (a[4:2] == 3'b000) || (a[4:1] == 4'b0011);
    endfunction

    assign rise      = clk_q & ~clk_prev_q;
    assign fall      = ~clk_q & clk_prev_q;
    assign last_edge = rise && (bit_cnt_q == 3'd7);
    assign in_byte   = {shift_q[6:0], rtc.rtc_data_i};

    // Byte a read command selects, decoded from the command as it completes.
    always_comb begin
        rd_addr = in_byte[6:2];
        rd_byte = 8'h00;
        if (is_pram(rd_addr)) begin
            rd_byte = pram_q[pram_index(rd_addr)];
        end else if (rd_addr[4:2] == 3'b000) begin
            rd_byte = seconds_q[{rd_addr[1:0], 3'b000} +: 8];
        end else if (rd_addr == 5'b00111) begin
            rd_byte = {wp_q, 7'b0000000};
        end
    end

    always_ff @(posedge clock) begin
        clk_q      <= rtc.rtc_clk;
        clk_prev_q <= clk_q;
        commit_q   <= 1'b0;
        if (reset) begin
            clk_q      <= 1'b1;
            clk_prev_q <= 1'b1;
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            addr_q     <= 5'd0;
            data_o_q   <= 1'b0;
            data_t_q   <= 1'b0;
        end else if (rtc.rtc_ce_n) begin
            state_q  <= StIdle;
            data_o_q <= 1'b0;
            data_t_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q   <= StCmd;
                    bit_cnt_q <= 3'd0;
                end
                StCmd: begin
                    if (rise) begin
                        shift_q   <= in_byte;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (last_edge) begin
                            addr_q <= in_byte[6:2];
                            if (in_byte[1:0] != 2'b01 || !addr_valid(in_byte[6:2])) begin
                                state_q <= StHold;
                            end else if (in_byte[7]) begin
                                state_q  <= StRdata;
                                shift_q  <= rd_byte;
                                data_o_q <= rd_byte[7];
                                data_t_q <= 1'b1;
                            end else begin
                                state_q <= StWdata;
                            end
                        end
                    end
                end
                StWdata: begin
                    if (rise) begin
                        shift_q   <= in_byte;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        // shift_q stays put in HOLD/IDLE, so it carries the byte into the commit.
                        if (last_edge) begin
                            commit_q <= 1'b1;
                            state_q  <= StHold;
                        end
                    end
                end
                StRdata: begin
                    if (fall) begin
                        shift_q  <= {shift_q[6:0], 1'b0};
                        data_o_q <= shift_q[6];
                    end
                    if (rise) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (last_edge) begin
                            state_q  <= StHold;
                            data_o_q <= 1'b0;
                            data_t_q <= 1'b0;
                        end
                    end
                end
                StHold: ;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seconds_q <= 32'h0000_0000;
            wp_q      <= 1'b1;
        end else begin
            if (time_set) begin
                seconds_q <= time_in;
            end else if (commit_q && !wp_q && addr_q[4:2] == 3'b000) begin
                seconds_q[{addr_q[1:0], 3'b000} +: 8] <= shift_q;
            end else if (sec_tick) begin
                seconds_q <= seconds_q + 32'd1;
            end
            if (commit_q && addr_q == 5'b00111) begin
                wp_q <= shift_q[7];
            end
        end
    end

    assign pram_we = commit_q && !wp_q && is_pram(addr_q) && !reset;

    always_ff @(posedge clock) begin
`ifdef MAC_RTC_PRAM_INIT_EN
        if (reset) begin
            for (int i = 0; i < 20; i++) begin
                pram_q[i] <= (i == 16) ? 8'hA8 : 8'h00;
            end
        end else
`endif
        if (pram_we) begin
            pram_q[pram_index(addr_q)] <= shift_q;
        end
    end

    assign rtc.rtc_data_o = data_o_q & data_t_q;
    assign rtc.rtc_data_t = data_t_q;

endmodule

// File: tb/tb_mac_rtc.sv
// Directed bench for mac_rtc: serial reads/writes, write protect, seconds counter rules.
// Expected bytes come from a small register-map model plus literal pins.
module tb_mac_rtc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sec_tick = 1'b0;
    logic        time_set = 1'b0;
    logic [31:0] time_in = 32'h0;

    mac_rtc_if rtc ();

    mac_rtc dut (
        .clock    (clock),
        .reset    (reset),
        .sec_tick (sec_tick),
        .time_set (time_set),
        .time_in  (time_in),
        .rtc      (rtc)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    logic        check_on = 1'b0;
    logic        exp_t = 1'b0;
    logic        exp_o = 1'b0;
    string       chk_name = "";
    logic        val_on = 1'b0;
    logic [31:0] val_got = 32'h0;
    logic [31:0] val_want = 32'h0;
    string       val_name = "";

    // Register-map model
    logic [31:0] m_sec = 32'h0;
    logic        m_wp = 1'b1;
    logic [7:0]  m_pram [20] = '{default: 8'h00};

    function automatic int pram_slot(input logic [4:0] a);
        if (int'(a) >= 16) return int'(a) - 16;
        if (int'(a) >= 8 && int'(a) <= 11) return 16 + int'(a) - 8;
        return -1;
    endfunction

    function automatic logic [7:0] m_read(input logic [4:0] a);
        int s;
        s = pram_slot(a);
        if (s >= 0) return m_pram[s];
        if (int'(a) < 4) return m_sec[int'(a) * 8 +: 8];
        return 8'h00;
    endfunction

    task automatic m_commit(input logic [7:0] cmd, input logic [7:0] data, input bit tick);
        logic [4:0] a;
        int         s;
        bit         sec_written;
        a = cmd[6:2];
        s = pram_slot(a);
        sec_written = 1'b0;
        if (cmd[7] == 1'b0 && cmd[1:0] == 2'b01) begin
            if (int'(a) == 7) begin
                m_wp = data[7];
            end else if (!m_wp) begin
                if (s >= 0) begin
                    m_pram[s] = data;
                end else if (int'(a) < 4) begin
                    m_sec[int'(a) * 8 +: 8] = data;
                    sec_written = 1'b1;
                end
            end
        end
        if (tick && !sec_written) m_sec = m_sec + 32'd1;
    endtask

    task automatic m_reset();
        m_sec = 32'h0;
        m_wp = 1'b1;
`ifdef MAC_RTC_PRAM_INIT_EN
        for (int i = 0; i < 20; i++) m_pram[i] = (i == 16) ? 8'hA8 : 8'h00;
`endif
    endtask

    // Single compare process: output checks, value checks, and idle-line rule.
    always @(negedge clock) begin
        if (check_on) begin
            total++;
            if (rtc.rtc_data_t !== exp_t || rtc.rtc_data_o !== exp_o) begin
                bad++;
                $display("FAIL %s: got t=%b o=%b, want t=%b o=%b", chk_name,
                         rtc.rtc_data_t, rtc.rtc_data_o, exp_t, exp_o);
            end
        end
        if (val_on) begin
            total++;
            if (val_got !== val_want) begin
                bad++;
                $display("FAIL %s: got 0x%08h, want 0x%08h", val_name, val_got, val_want);
            end
        end
        if (!reset && rtc.rtc_data_t === 1'b0) begin
            total++;
            if (rtc.rtc_data_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_data_o: got %b, want 0", rtc.rtc_data_o);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input logic t, input logic o, input string name);
        exp_t = t;
        exp_o = o;
        chk_name = name;
        check_on = 1'b1;
        @(negedge clock);
        #1 check_on = 1'b0;
    endtask

    task automatic check_val(input logic [31:0] got, input logic [31:0] want, input string name);
        val_got = got;
        val_want = want;
        val_name = name;
        val_on = 1'b1;
        @(negedge clock);
        #1 val_on = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rtc.rtc_ce_n = 1'b1;
        rtc.rtc_clk = 1'b1;
        rtc.rtc_data_i = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        m_reset();
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        cyc(1);
        sec_tick = 1'b0;
        m_sec = m_sec + 32'd1;
    endtask

    task automatic load_time(input logic [31:0] v);
        time_in = v;
        time_set = 1'b1;
        cyc(1);
        time_set = 1'b0;
        m_sec = v;
    endtask

    task automatic begin_xfer();
        rtc.rtc_ce_n = 1'b0;
        cyc(2);
    endtask

    task automatic end_xfer();
        rtc.rtc_ce_n = 1'b1;
        cyc(2);
    endtask

    task automatic send_bit(input logic b);
        rtc.rtc_clk = 1'b0;
        rtc.rtc_data_i = b;
        cyc(3);
        rtc.rtc_clk = 1'b1;
        cyc(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // tick_at_commit puts sec_tick in the exact cycle the byte commits.
    task automatic write_byte(input logic [7:0] cmd, input logic [7:0] data, input bit tick_at_commit);
        begin_xfer();
        send_byte(cmd);
        for (int i = 7; i >= 1; i--) send_bit(data[i]);
        rtc.rtc_clk = 1'b0;
        rtc.rtc_data_i = data[0];
        cyc(3);
        rtc.rtc_clk = 1'b1;
        if (tick_at_commit) begin
            cyc(2);
            sec_tick = 1'b1;
            cyc(1);
            sec_tick = 1'b0;
            cyc(1);
        end else begin
            cyc(4);
        end
        m_commit(cmd, data, tick_at_commit);
        end_xfer();
    endtask

    task automatic read_check(input logic [7:0] cmd, input logic [7:0] lit, input string name,
                              input bit tick_mid);
        logic [7:0] e;
        logic [7:0] got;
        e = m_read(cmd[6:2]);
        check_val(32'(e), 32'(lit), {name, "_model"});
        begin_xfer();
        send_byte(cmd);
        for (int i = 7; i >= 0; i--) begin
            got[i] = rtc.rtc_data_o;
            expect_out(1'b1, e[i], name);
            if (tick_mid && i == 4) tick();
            rtc.rtc_clk = 1'b0;
            cyc(3);
            rtc.rtc_clk = 1'b1;
            cyc(3);
        end
        expect_out(1'b0, 1'b0, {name, "_release"});
        check_val(32'(got), 32'(lit), name);
        end_xfer();
    endtask

    initial begin
        logic [7:0] pram10_init;
`ifdef MAC_RTC_PRAM_INIT_EN
        pram10_init = 8'hA8;
`else
        pram10_init = 8'h00;
`endif
        rtc.rtc_ce_n = 1'b1;
        rtc.rtc_clk = 1'b1;
        rtc.rtc_data_i = 1'b0;
        #1;
        do_reset();
        expect_out(1'b0, 1'b0, "reset_out");
        read_check(8'h81, 8'h00, "reset_sec0", 1'b0);

        // Write protect active after reset: PRAM write is dropped.
        write_byte(8'h21, 8'h33, 1'b0);
        write_byte(8'h1D, 8'h00, 1'b0);
        read_check(8'hA1, pram10_init, "wp_discard", 1'b0);

        // Unassigned code 0x35 does nothing; clear wp, write and read PRAM.
        do_reset();
        write_byte(8'h35, 8'h00, 1'b0);
        write_byte(8'h1D, 8'h00, 1'b0);
        write_byte(8'h21, 8'h5A, 1'b0);
        read_check(8'hA1, 8'h5A, "pram10_rw", 1'b0);
        write_byte(8'h41, 8'hC6, 1'b0);
        read_check(8'hC1, 8'hC6, "pram00_rw", 1'b0);

        // Seconds wrap and byte order.
        load_time(32'hFFFF_FFFF);
        tick();
        read_check(8'h81, 8'h00, "wrap_b0", 1'b0);
        read_check(8'h85, 8'h00, "wrap_b1", 1'b0);
        read_check(8'h89, 8'h00, "wrap_b2", 1'b0);
        read_check(8'h8D, 8'h00, "wrap_b3", 1'b0);
        load_time(32'h1234_5678);
        read_check(8'h89, 8'h34, "sec_b2", 1'b0);
        read_check(8'h81, 8'h78, "sec_latched", 1'b1);
        read_check(8'h81, 8'h79, "sec_after_tick", 1'b0);
        read_check(8'h8D, 8'h12, "sec_b3", 1'b0);

        // Byte commit beats a same-cycle tick.
        load_time(32'h0000_0005);
        write_byte(8'h01, 8'h10, 1'b1);
        read_check(8'h81, 8'h10, "commit_vs_tick", 1'b0);
        read_check(8'h85, 8'h00, "commit_vs_tick_b1", 1'b0);

        write_byte(8'h19, 8'hFF, 1'b0);
        read_check(8'h99, 8'h00, "test_reg_read", 1'b0);

        // Abort a PRAM write after 4 data bits.
        begin_xfer();
        send_byte(8'h21);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rtc.rtc_ce_n = 1'b1;
        cyc(1);
        expect_out(1'b0, 1'b0, "abort_release");
        cyc(2);
        read_check(8'hA1, 8'h5A, "abort_no_commit", 1'b0);

        // Bad command tails: nothing driven, trailing bits ignored.
        begin_xfer();
        send_byte(8'h23);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            expect_out(1'b0, 1'b0, "badcmd_wr_hold");
        end
        end_xfer();
        begin_xfer();
        send_byte(8'hA3);
        for (int i = 0; i < 8; i++) begin
            expect_out(1'b0, 1'b0, "badcmd_rd_nodrive");
            send_bit(1'b0);
        end
        end_xfer();
        read_check(8'hA1, 8'h5A, "badcmd_no_write", 1'b0);

        // Write protect set: seconds and PRAM writes dropped.
        write_byte(8'h1D, 8'h80, 1'b0);
        write_byte(8'h01, 8'h99, 1'b0);
        read_check(8'h81, 8'h10, "wp_sec_discard", 1'b0);
        write_byte(8'h21, 8'h11, 1'b0);
        read_check(8'hA1, 8'h5A, "wp_pram_discard", 1'b0);

        // Reset lands in the commit cycle: no write.
        write_byte(8'h1D, 8'h00, 1'b0);
        begin_xfer();
        send_byte(8'h21);
        for (int i = 7; i >= 1; i--) send_bit(1'b1);
        rtc.rtc_clk = 1'b0;
        rtc.rtc_data_i = 1'b0;
        cyc(3);
        rtc.rtc_clk = 1'b1;
        cyc(2);
        reset = 1'b1;
        rtc.rtc_ce_n = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        m_reset();
`ifdef MAC_RTC_PRAM_INIT_EN
        read_check(8'hA1, 8'hA8, "reset_mid_commit", 1'b0);
`else
        read_check(8'hA1, 8'h5A, "reset_mid_commit", 1'b0);
`endif
        read_check(8'h81, 8'h00, "reset_mid_sec", 1'b0);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
